// File: rtl/uart_rx_cfg_pkg.sv
// Shared UART definitions: parity codes, receiver FSM encoding, baud divisor.
package uart_rx_cfg_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest; never below 1.
  function automatic int baud_div(input int clk_freq, input int baud, input int os);
    int d;
    d = (clk_freq + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Receiver-side signal bundle: raw line in, received word and status out.
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;

  modport master (
    input  serial_in,
    output data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    output serial_in,
    input  data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_cfg_baud_tick.sv
// Oversample tick generator; counter held at 0 while disabled so the
// tick phase lines up with the moment it is enabled.
module uart_rx_cfg_baud_tick
  import uart_rx_cfg_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam logic [31:0] DIV = 32'(baud_div(CLK_FREQ, BAUD, OVERSAMPLE));

  logic [31:0] ctr;

  // Divide clk down to one-cycle ticks while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ctr <= '0;
    else if (!en || ctr == DIV - 32'd1) ctr <= '0;
    else                              ctr <= ctr + 32'd1;
  end

  assign tick = en && (ctr == DIV - 32'd1);
endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver: 2-FF synchroniser, 16x oversampling with 3-sample
// majority per bit, optional parity, 1 or 2 stop bits.
module uart_rx_cfg
  import uart_rx_cfg_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_cfg_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_DEC = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_e            state, state_nx;
  logic                 rx_meta, rx_s, rx_d;
  logic                 tick, decide, bit_end, maj, start_edge, stop_last;
  logic [TW-1:0]        tick_ctr;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shreg, data_q;
  logic                 par_acc, par_flag, frame_flag;
  logic                 valid_q, perr_q, ferr_q;

  uart_rx_cfg_baud_tick #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk(clk), .rst(rst), .en(state != ST_IDLE), .tick(tick)
  );

  assign start_edge = rx_d && !rx_s;
  assign decide     = tick && (tick_ctr == T_DEC);
  assign bit_end    = tick && (tick_ctr == T_END);
  // Third sample is the live synchronised line at the decision tick.
  assign maj        = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign stop_last  = (STOP_BITS == 1) || stop_idx;

  // Synchronise the pin and keep one extra stage for falling-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {rx_meta, rx_s, rx_d} <= 3'b111;
    else     {rx_meta, rx_s, rx_d} <= {bus.serial_in, rx_meta, rx_s};
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state; the final stop bit exits at its decision tick so a
  // back-to-back start edge right after it is not missed.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (start_edge) state_nx = ST_START;
      ST_START:  if (decide && maj) state_nx = ST_IDLE;
                 else if (bit_end) state_nx = ST_DATA;
      ST_DATA:   if (bit_end && bit_idx == LAST_BIT)
                   state_nx = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_end) state_nx = ST_STOP;
      ST_STOP:   if (decide && stop_last) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Bit timing, sampling, shift register, error flags and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_ctr   <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      smp        <= 2'b11;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_flag   <= 1'b0;
      frame_flag <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (state == ST_IDLE) begin
        tick_ctr <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        if (start_edge) begin
          shreg      <= '0;
          par_acc    <= 1'b0;
          par_flag   <= 1'b0;
          frame_flag <= 1'b0;
        end
      end else if (tick) begin
        tick_ctr <= (tick_ctr == T_END) ? '0 : tick_ctr + TW'(1);
        if (tick_ctr == T_S0) smp[0] <= rx_s;
        if (tick_ctr == T_S1) smp[1] <= rx_s;
        if (decide) begin
          case (state)
            ST_DATA: begin
              shreg[bit_idx] <= maj;
              par_acc        <= par_acc ^ maj;
            end
            ST_PARITY: par_flag <= maj ^ par_acc ^ (PARITY == PARITY_ODD);
            ST_STOP: begin
              if (!maj) frame_flag <= 1'b1;
              if (stop_last) begin
                data_q  <= shreg;
                perr_q  <= par_flag;
                ferr_q  <= frame_flag | ~maj;
                valid_q <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        if (bit_end) begin
          if (state == ST_DATA && bit_idx != LAST_BIT) bit_idx <= bit_idx + BW'(1);
          if (state == ST_STOP) stop_idx <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state != ST_IDLE);
endmodule
